// File: rtl/b_decode_pkg.sv
// rtl/b_decode_pkg.sv - shared constants, types and helpers for the B-form decoder
package b_decode_pkg;

  localparam int ADDR_W = 64;
  localparam int PID_W  = 20;
  localparam int TID_W  = 16;
  localparam int MAJ_W  = 64;
  localparam int OPC_W  = 12;
  localparam int FU_W   = 3;

  localparam logic [OPC_W-1:0] OPC_BC   = 12'h040;
  localparam logic [OPC_W-1:0] OPC_BCL  = 12'h041;
  localparam logic [OPC_W-1:0] OPC_BCA  = 12'h042;
  localparam logic [OPC_W-1:0] OPC_BCLA = 12'h043;

  localparam logic [FU_W-1:0] FX_UNIT_ID     = 3'd0;
  localparam logic [FU_W-1:0] FP_UNIT_ID     = 3'd1;
  localparam logic [FU_W-1:0] VX_UNIT_ID     = 3'd2;
  localparam logic [FU_W-1:0] CR_UNIT_ID     = 3'd3;
  localparam logic [FU_W-1:0] LS_UNIT_ID     = 3'd4;
  localparam logic [FU_W-1:0] BRANCH_UNIT_ID = 3'd6;

  localparam int I_FORMAT_BIT  = 0;
  localparam int B_FORMAT_BIT  = 1;
  localparam int SC_FORMAT_BIT = 2;

  localparam logic [5:0] BC_PRIMARY_OPCODE = 6'd16;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [FU_W-1:0]   fu;
    logic              aa;
    logic              lk;
    logic [4:0]        bo;
    logic [4:0]        bi;
    logic              ctr_dec;
    logic              is64;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] target;
    logic [MAJ_W-1:0]  majid;
    logic [PID_W-1:0]  pid;
    logic [TID_W-1:0]  tid;
  } b_entry_t;

  function automatic logic [OPC_W-1:0] bc_opcode(input logic aa, input logic lk);
    return OPC_BC | {{(OPC_W-2){1'b0}}, aa, lk};
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// rtl/decode_fifo.sv - parametrised synchronous FIFO with occupancy count
module decode_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign rdata_o = r_mem[r_rd_ptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  // Storage is cleared on reset so the payload outputs read zero afterwards.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata_i;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/b_format_decoder_pipe.sv
// rtl/b_format_decoder_pipe.sv - B-form conditional branch decoder with output FIFO
module b_format_decoder_pipe
  import b_decode_pkg::*;
#(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int opcodeSize              = 12,
  parameter int funcUnitCodeSize        = 3,
  parameter int DEPTH                   = 4,
  parameter int BFormatBit              = B_FORMAT_BIT
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  output logic                               ready_o,
  input  logic [25:0]                        instFormat_i,
  input  logic [instructionWidth-1:0]        instruction_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic [instructionCounterWidth-1:0] instructionMajId_i,
  input  logic                               stall_i,
  output logic                               enable_o,
  output logic [opcodeSize-1:0]              opcode_o,
  output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic [instructionCounterWidth-1:0] instMajId_o,
  output logic [instMinIdWidth-1:0]          instMinId_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instPid_o,
  output logic [TidSize-1:0]                 instTid_o,
  output logic [4:0]                         BO_o,
  output logic [4:0]                         BI_o,
  output logic [addressWidth-1:0]            target_o,
  output logic                               AA_o,
  output logic                               LK_o,
  output logic                               ctrDecrement_o,
  output logic                               illegal_o,
  output logic [$clog2(DEPTH+1)-1:0]         count_o
);
  logic                    w_is_b;
  logic                    w_opc_ok;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_illegal;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_unused;
  logic [addressWidth-1:0] w_ext;
  logic [addressWidth-1:0] w_sum;
  logic [addressWidth-1:0] w_target;
  b_entry_t                w_entry;
  b_entry_t                w_head;
  logic                    r_illegal;

  // Instruction bit k in big-endian numbering is instruction_i[31-k].
  assign w_is_b    = instFormat_i[BFormatBit];
  assign w_opc_ok  = (instruction_i[31:26] == BC_PRIMARY_OPCODE);
  assign w_accept  = enable_i & ready_o & w_is_b;
  assign w_push    = w_accept & w_opc_ok;
  assign w_illegal = w_accept & ~w_opc_ok;
  assign w_unused  = ^instFormat_i;

  assign w_ext = {{(addressWidth-16){instruction_i[15]}}, instruction_i[15:2], 2'b00};
  assign w_sum = instruction_i[1] ? w_ext : instructionAddress_i + w_ext;

  always_comb begin
    w_target = w_sum;
    if (!is64Bit_i) w_target[addressWidth-1:32] = '0;
  end

  always_comb begin
    w_entry         = '0;
    w_entry.opcode  = bc_opcode(instruction_i[1], instruction_i[0]);
    w_entry.fu      = BRANCH_UNIT_ID;
    w_entry.aa      = instruction_i[1];
    w_entry.lk      = instruction_i[0];
    w_entry.bo      = instruction_i[25:21];
    w_entry.bi      = instruction_i[20:16];
    w_entry.ctr_dec = ~instruction_i[23];
    w_entry.is64    = is64Bit_i;
    w_entry.addr    = instructionAddress_i;
    w_entry.target  = w_target;
    w_entry.majid   = instructionMajId_i;
    w_entry.pid     = instructionPid_i;
    w_entry.tid     = instructionTid_i;
  end

  decode_fifo #(.DEPTH(DEPTH), .WIDTH($bits(b_entry_t))) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (w_push),
    .wdata_i (w_entry),
    .pop_i   (enable_o & ~stall_i),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (count_o)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) r_illegal <= 1'b0;
    else          r_illegal <= w_illegal;
  end

  assign ready_o              = ~w_full;
  assign enable_o             = ~w_empty;
  assign illegal_o            = r_illegal;
  assign opcode_o             = w_head.opcode;
  assign functionalUnitType_o = w_head.fu;
  assign instructionAddress_o = w_head.addr;
  assign instMajId_o          = w_head.majid;
  assign instMinId_o          = '0;
  assign is64Bit_o            = w_head.is64;
  assign instPid_o            = w_head.pid;
  assign instTid_o            = w_head.tid;
  assign BO_o                 = w_head.bo;
  assign BI_o                 = w_head.bi;
  assign target_o             = w_head.target;
  assign AA_o                 = w_head.aa;
  assign LK_o                 = w_head.lk;
  assign ctrDecrement_o       = w_head.ctr_dec;

endmodule

// File: doc/b_format_decoder_pipe.md
Name: b_format_decoder_pipe

Overview:
- Second-generation B-form (conditional branch, primary opcode 16) decoder for the decode stage.
- Sits between the format-detect stage and decode-to-issue arbitration.
- Unlike the first-generation decoder, it runs a valid/ready handshake into a parametrised-depth output FIFO instead of a single stall-gated register.
- It also fully decodes BO/BI/AA/LK, computes the branch target address (64- and 32-bit modes), and flags B-format words with an illegal primary opcode.

Parameters:
addressWidth, 64, instruction address / target width
instructionWidth, 32, instruction word width
PidSize, 20, process ID width
TidSize, 16, thread ID width
instructionCounterWidth, 64, major ID width
instMinIdWidth, 7, minor ID width
opcodeSize, 12, decoded opcode width
funcUnitCodeSize, 3, functional unit code width
DEPTH, 4, output FIFO entries (power of two, ≥2)
BFormatBit, 1, bit index of the B-format flag in instFormat_i

Ports:
clock_i  in  1  clock
reset_i  in  1  asynchronous, active-low reset
enable_i  in  1  input valid
ready_o  out  1  input ready (FIFO not full)
instFormat_i  in  26  one-hot format vector
instruction_i  in  instructionWidth  instruction word, bits [0:31] big-endian
instructionAddress_i  in  addressWidth  instruction address
is64Bit_i  in  1  64-bit mode
instructionPid_i  in  PidSize  process ID
instructionTid_i  in  TidSize  thread ID
instructionMajId_i  in  instructionCounterWidth  major ID
stall_i  in  1  downstream not accepting
enable_o  out  1  output valid (FIFO non-empty)
opcode_o  out  opcodeSize  decoded opcode: OPC_BC | {AA,LK}
functionalUnitType_o  out  funcUnitCodeSize  always BranchUnitID (6)
instructionAddress_o  out  addressWidth  instruction address
instMajId_o  out  instructionCounterWidth  major ID
instMinId_o  out  instMinIdWidth  always 0
is64Bit_o  out  1  mode
instPid_o  out  PidSize  process ID
instTid_o  out  TidSize  thread ID
BO_o  out  5  instruction[6:10]
BI_o  out  5  instruction[11:15]
target_o  out  addressWidth  branch target
AA_o, LK_o  out  1 each  instruction[30], instruction[31]
ctrDecrement_o  out  1  !BO[2], i.e. !instruction[8]
illegal_o  out  1  one-cycle pulse: B-format word with primary opcode ≠ 16
count_o  out  clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (reset_i low, asynchronous): count = 0, pointers = 0, every output = 0 (ready_o = 1 once reset deasserts). Reset takes effect mid-operation and discards all entries immediately.
- Push condition: enable_i & ready_o & instFormat_i[BFormatBit] & (instruction_i[0:5] == 16).
- Illegal: enable_i & ready_o & format bit set & opcode ≠ 16. No push; illegal_o = 1 on the next cycle only.
- Non-B-format input: ignored. No push, no illegal_o.
- ready_o = (count != DEPTH). It is combinational from count only and never depends on stall_i.
- Pop condition: enable_o & !stall_i. The head advances at the clock edge.
- Latency: a word accepted at edge N is visible on the outputs after edge N (1 cycle), provided it is the head.
- Push and pop in the same cycle: count is unchanged.
- Full: no push; pop allowed.
- Empty: enable_o = 0. The payload outputs hold their last value (don't-care).
- Pointers are log2(DEPTH) bits and wrap naturally.
- Target computation:
  - ext = signExtend(instruction[16:29]) << 2, at addressWidth bits.
  - target = AA ? ext : address + ext, modulo 2^addressWidth.
  - If !is64Bit, bits [0:31] of target are forced to 0.
  - target is computed at push and stored in the entry.
- Ordering: strict FIFO; major IDs leave in arrival order.

Decomposition:
- Package b_decode_pkg:
  - OPC_BC base value (12'h040); OPC_BC..OPC_BCLA = base + {AA,LK}.
  - Functional-unit IDs (FX=0, FP=1, VX=2, CR=3, LS=4, Branch=6).
  - Format bit indices.
  - Branch entry struct (payload fields).
- One sub-module: decode_fifo, a parametrised DEPTH × width sync FIFO with count, used for the payload store.
- Decode and target arithmetic stay in the top level.

Test Plan:
1. bc, AA=0 LK=1, addr 0x1000, BD=0x0010, 64-bit → next cycle enable_o=1, target_o=0x1040, opcode_o=OPC_BC+1, LK_o=1, functionalUnitType_o=6.
2. AA=1, BD=0x3FFF (−1), addr 0x2000 → target_o=0xFFFF_FFFF_FFFF_FFFC in 64-bit; 0x0000_0000_FFFF_FFFC with is64Bit_i=0.
3. 32-bit wrap: addr 0xFFFF_FFFC, BD=2, AA=0, is64Bit_i=0 → target_o=0x4, upper 32 bits zero.
4. DEPTH=4, stall_i=1, 5 back-to-back pushes (MajId 1..5):
   - ready_o drops after the 4th push; count_o=4; MajId 5 is held.
   - Release stall → outputs MajId 1,2,3,4 on consecutive cycles, then MajId 5 is accepted and delivered.
5. Format bit set, opcode 18 → illegal_o high exactly 1 cycle, enable_o stays 0, count_o unchanged. Same word without the format bit → no illegal_o.
6. With 3 entries queued, pull reset_i low mid-cycle → enable_o, count_o and all payload outputs go to 0 without a clock edge. After release, ready_o=1 and the old entries never appear.
